demux_1to4_stream: RTL
======================

// Module: demux_1to4_stream
// PURPOSE
//  Registered 1-to-4 stream demultiplexer; inverse of the 4:1 select mux.
//  Routes one input beat, with a 2-bit select, to one of four output channels.
//  Valid/ready handshake on every port; one holding register per channel.
//  A stalled channel never blocks traffic to the other channels.
// PARAMETERS
//  DATA_W   4  data width per beat (all channels)
//  CNT_W    8  width of per-channel beat counters (DEMUX_CNT_EN only)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous reset, active-high
//  in_valid   in   1         input beat present
//  in_ready   out  1         input beat accepted when in_valid & in_ready
//  in_data    in   DATA_W    input beat
//  sel        in   2         destination: 00->A, 01->B, 10->C, 11->D
//  out_valid  out  4         per-channel valid, bit0=A .. bit3=D
//  out_ready  in   4         per-channel ready, bit0=A .. bit3=D
//  out_a/b/c/d out DATA_W    per-channel data, registered
//  cnt_a/b/c/d out CNT_W     accepted-beat counters (DEMUX_CNT_EN only)
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=4'b0, out_a..out_d=0, counters=0.
//    Reset mid-transfer discards all held beats; no partial output.
//  - Per channel k: slot holds one beat; full_k == out_valid[k].
//  - in_ready = ~out_valid[sel] | out_ready[sel]  (combinational, sel-dependent).
//  - Accept (in_valid & in_ready): on the next edge slot[sel] loads in_data,
//    out_valid[sel]<=1. Latency: accept edge -> out_valid high 1 cycle later.
//  - Drain: out_valid[k] & out_ready[k] with no load to k -> out_valid[k]<=0.
//  - Simultaneous drain and load on same channel: slot reloads, out_valid
//    stays 1; full throughput of 1 beat/cycle to one channel.
//  - Loads to channel j and drains on other channels in same cycle proceed
//    independently; up to 4 drains per cycle.
//  - out_x holds its last value while out_valid[x]=0 (no clearing on drain).
//  - Protocol: once in_valid=1 with in_ready=0, in_data and sel are held
//    stable until accepted; out_data stable while out_valid & ~out_ready.
//  - No X on outputs after reset; sel fully decoded, no illegal code.
// CONFIGURATION
//  DEMUX_CNT_EN defined: four CNT_W counters, cnt_k increments on each
//   accepted beat routed to k, wraps 2^CNT_W-1 -> 0; reset to 0.
//  DEMUX_CNT_EN undefined: cnt_* ports and counter logic absent.
// STRUCTURE
//  demux_pkg: NUM_CH=4, SEL_W=2, CH_A..CH_D select constants.
//  Sub-module demux_out_slot (one per channel, x4): load/valid/ready/data
//   register slice; top holds decode, in_ready mux, optional counters.
// TESTING
//  1 rst=1 mid-run with slots full -> out_valid=0, data=0 same cycle (async).
//  2 sel=10,data=4'hA,out_ready=4'hF -> out_valid=4'b0100, out_c=A next cycle.
//  3 out_ready[B]=0, send 2 beats to B -> 1st held, in_ready=0 on 2nd;
//    beat to D same period accepted, out_d valid 1 cycle later.
//  4 Back-to-back 8 beats to A, out_ready[A]=1 -> 1 beat/cycle, in order.
//  5 Random sel/data/ready, 10k cycles -> scoreboard per channel, no loss/dup.
//  6 DEMUX_CNT_EN, CNT_W=8: 257 beats to C -> cnt_c=1, others 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer: channel count,
// select width, channel select codes and the select decoder.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  // Select codes: 00->A, 01->B, 10->C, 11->D
  typedef enum logic [SEL_W-1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;

  // One-hot channel strobe for a select code; every code is legal.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (s)
      CH_A:    oh[0] = 1'b1;
      CH_B:    oh[1] = 1'b1;
      CH_C:    oh[2] = 1'b1;
      default: oh[3] = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Single-beat output holding register for one demux channel.
// A load always wins over a drain, so a simultaneous drain and load
// keeps the slot full and sustains one beat per cycle. Data is not
// cleared on drain; it holds the last loaded beat.
module demux_out_slot #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data_out
);

  // Slot state: load sets full and captures data, a drain clears full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (ready) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on every port.
// Each channel owns one holding slot, so a stalled channel only stalls
// beats addressed to it. Optional per-channel accepted-beat counters are
// built when the macro DEMUX_CNT_EN is defined.
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 4
`ifdef DEMUX_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_c,
  output logic [CNT_W-1:0]  cnt_d
`endif
);

  logic              in_fire;
  logic [NUM_CH-1:0] load;
  logic [DATA_W-1:0] slot_data [NUM_CH];

  // Input may be taken when the addressed slot is empty or draining now.
  always_comb begin
    in_ready = ~out_valid[sel] | out_ready[sel];
    in_fire  = in_valid & in_ready;
    load     = in_fire ? sel_onehot(sel) : '0;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data_in  (in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data_out (slot_data[k])
    );
  end

  assign out_a = slot_data[CH_A];
  assign out_b = slot_data[CH_B];
  assign out_c = slot_data[CH_C];
  assign out_d = slot_data[CH_D];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_CH];

  // Count accepted beats per destination; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (load[i]) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign cnt_a = cnt[CH_A];
  assign cnt_b = cnt[CH_B];
  assign cnt_c = cnt[CH_C];
  assign cnt_d = cnt[CH_D];
`endif

endmodule
